// File: rtl/ili9341_defines.sv
// ILI9341 shared definitions: command opcodes and the RGB565 pixel layout.
package ili9341_defines;

  typedef enum logic [7:0] {
    NOP     = 8'h00,
    SWRESET = 8'h01,
    CASET   = 8'h2A,
    PASET   = 8'h2B,
    RAMWR   = 8'h2C
  } ILI9341_register_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } ILI9341_color_t;

endpackage

// File: rtl/ili9341_spi_responder_spi_byte_receiver.sv
// SPI mode-0 byte receiver, oversampled in the clk domain.
// Ports:
//   clk, rstb      system clock, asynchronous active-low reset
//   i_csb          chip select (active low, asynchronous)
//   i_sclk         SPI clock (asynchronous, at most clk/4)
//   i_mosi         serial data, MSB first
//   i_dc           D/CX, captured together with bit 0 of each byte
//   o_byte_valid   one-cycle pulse when a full byte has been received
//   o_byte, o_dc   received byte and its D/CX flag (valid with o_byte_valid)
module spi_byte_receiver (
  input  logic       clk,
  input  logic       rstb,
  input  logic       i_csb,
  input  logic       i_sclk,
  input  logic       i_mosi,
  input  logic       i_dc,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_dc
);

  logic [1:0] r_csb_s;
  logic [1:0] r_sclk_s;
  logic [1:0] r_mosi_s;
  logic [1:0] r_dc_s;
  logic       r_sclk_d;
  logic [7:0] r_shift;
  logic [2:0] r_cnt;
  logic       r_done;
  logic [7:0] r_byte;
  logic       r_dc;
  logic       r_out_valid;
  logic [7:0] r_out_byte;
  logic       r_out_dc;

  logic       w_csb;
  logic       w_rise;
  logic [7:0] w_next_shift;

  assign w_csb        = r_csb_s[1];
  assign w_rise       = r_sclk_s[1] & ~r_sclk_d;
  assign w_next_shift = {r_shift[6:0], r_mosi_s[1]};

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_csb_s     <= 2'b11;
      r_sclk_s    <= 2'b00;
      r_mosi_s    <= 2'b00;
      r_dc_s      <= 2'b00;
      r_sclk_d    <= 1'b0;
      r_shift     <= 8'h00;
      r_cnt       <= 3'd0;
      r_done      <= 1'b0;
      r_byte      <= 8'h00;
      r_dc        <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_byte  <= 8'h00;
      r_out_dc    <= 1'b0;
    end else begin
      r_csb_s  <= {r_csb_s[0], i_csb};
      r_sclk_s <= {r_sclk_s[0], i_sclk};
      r_mosi_s <= {r_mosi_s[0], i_mosi};
      r_dc_s   <= {r_dc_s[0], i_dc};
      r_sclk_d <= r_sclk_s[1];
      r_done   <= 1'b0;
      // Deselect drops any partial byte; the decoder state above is untouched.
      if (w_csb) begin
        r_cnt <= 3'd0;
      end else if (w_rise) begin
        r_shift <= w_next_shift;
        r_cnt   <= r_cnt + 3'd1;
        if (r_cnt == 3'd7) begin
          r_done <= 1'b1;
          r_byte <= w_next_shift;
          r_dc   <= r_dc_s[1];
        end
      end
      // Output register stage keeps the command/pixel latency at 4 clk from the bit-0 sample.
      r_out_valid <= r_done;
      r_out_byte  <= r_byte;
      r_out_dc    <= r_dc;
    end
  end

  assign o_byte_valid = r_out_valid;
  assign o_byte       = r_out_byte;
  assign o_dc         = r_out_dc;

endmodule

// File: rtl/ili9341_spi_responder.sv
// ILI9341 display-side SPI responder: decodes commands, tracks the
// CASET/PASET window and emits one strobe per RGB565 pixel after RAMWR.
// Ports:
//   clk, rstb            system clock, asynchronous active-low reset
//   spi_csb/clk/mosi     4-wire SPI bus (mode 0) plus data_commandb (D/CX)
//   spi_miso             tied low, write-only model
//   cmd_valid, cmd       command strobe and last command byte
//   px_valid, px_x, px_y, px_color   pixel strobe, coordinates, RGB565
//   frame_done           pulses with the pixel at (EC, EP)
module ili9341_spi_responder
  import ili9341_defines::*;
#(
  parameter int DISPLAY_WIDTH  = 240,
  parameter int DISPLAY_HEIGHT = 320,
  parameter int X_W            = $clog2(DISPLAY_WIDTH) + 1,
  parameter int Y_W            = $clog2(DISPLAY_HEIGHT) + 1
) (
  input  logic           clk,
  input  logic           rstb,
  input  logic           spi_csb,
  input  logic           spi_clk,
  input  logic           spi_mosi,
  output logic           spi_miso,
  input  logic           data_commandb,
  output logic           cmd_valid,
  output logic [7:0]     cmd,
  output logic           px_valid,
  output logic [X_W-1:0] px_x,
  output logic [Y_W-1:0] px_y,
  output logic [15:0]    px_color,
  output logic           frame_done
);

  localparam logic [2:0] S_CMD   = 3'd0;
  localparam logic [2:0] S_CASET = 3'd1;
  localparam logic [2:0] S_PASET = 3'd2;
  localparam logic [2:0] S_RAMWR = 3'd3;
  localparam logic [2:0] S_SKIP  = 3'd4;

  localparam logic [15:0]    MAX_X  = 16'(DISPLAY_WIDTH - 1);
  localparam logic [15:0]    MAX_Y  = 16'(DISPLAY_HEIGHT - 1);
  localparam logic [X_W-1:0] RST_EC = X_W'(DISPLAY_WIDTH - 1);
  localparam logic [Y_W-1:0] RST_EP = Y_W'(DISPLAY_HEIGHT - 1);

  logic           w_byte_valid;
  logic [7:0]     w_byte;
  logic           w_dc;
  logic [15:0]    w_first;
  logic [15:0]    w_second;
  logic           w_win_ok;

  logic [2:0]     r_state;
  logic [1:0]     r_idx;
  logic [7:0]     r_p0;
  logic [7:0]     r_p1;
  logic [7:0]     r_p2;
  logic [X_W-1:0] r_sc;
  logic [X_W-1:0] r_ec;
  logic [Y_W-1:0] r_sp;
  logic [Y_W-1:0] r_ep;
  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           r_hi_pend;
  logic [7:0]     r_hi;
  logic           r_cmd_valid;
  logic [7:0]     r_cmd;
  logic           r_px_valid;
  logic [X_W-1:0] r_px_x;
  logic [Y_W-1:0] r_px_y;
  ILI9341_color_t r_px_color;
  logic           r_frame_done;

  spi_byte_receiver u_rx (
    .clk          (clk),
    .rstb         (rstb),
    .i_csb        (spi_csb),
    .i_sclk       (spi_clk),
    .i_mosi       (spi_mosi),
    .i_dc         (data_commandb),
    .o_byte_valid (w_byte_valid),
    .o_byte       (w_byte),
    .o_dc         (w_dc)
  );

  // Start/end of the incoming window, available while the 4th parameter byte is present.
  assign w_first  = {r_p0, r_p1};
  assign w_second = {r_p2, w_byte};
  assign w_win_ok = (w_first <= w_second) &&
                    (w_second <= ((r_state == S_CASET) ? MAX_X : MAX_Y));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state      <= S_CMD;
      r_idx        <= 2'd0;
      r_p0         <= 8'h00;
      r_p1         <= 8'h00;
      r_p2         <= 8'h00;
      r_sc         <= '0;
      r_ec         <= RST_EC;
      r_sp         <= '0;
      r_ep         <= RST_EP;
      r_x          <= '0;
      r_y          <= '0;
      r_hi_pend    <= 1'b0;
      r_hi         <= 8'h00;
      r_cmd_valid  <= 1'b0;
      r_cmd        <= 8'(NOP);
      r_px_valid   <= 1'b0;
      r_px_x       <= '0;
      r_px_y       <= '0;
      r_px_color   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_cmd_valid  <= 1'b0;
      r_px_valid   <= 1'b0;
      r_frame_done <= 1'b0;
      if (w_byte_valid && !w_dc) begin
        // A command always wins: abort parameter collection and any pending high byte.
        r_cmd_valid <= 1'b1;
        r_cmd       <= w_byte;
        r_idx       <= 2'd0;
        r_hi_pend   <= 1'b0;
        case (w_byte)
          CASET:   r_state <= S_CASET;
          PASET:   r_state <= S_PASET;
          RAMWR: begin
            r_state <= S_RAMWR;
            r_x     <= r_sc;
            r_y     <= r_sp;
          end
          SWRESET: begin
            r_state <= S_CMD;
            r_sc    <= '0;
            r_ec    <= RST_EC;
            r_sp    <= '0;
            r_ep    <= RST_EP;
          end
          default: r_state <= S_SKIP;
        endcase
      end else if (w_byte_valid) begin
        case (r_state)
          S_CASET, S_PASET: begin
            r_idx <= r_idx + 2'd1;
            case (r_idx)
              2'd0: r_p0 <= w_byte;
              2'd1: r_p1 <= w_byte;
              2'd2: r_p2 <= w_byte;
              default: begin
                // Invalid windows are dropped silently; the previous window stays.
                if (w_win_ok) begin
                  if (r_state == S_CASET) begin
                    r_sc <= w_first[X_W-1:0];
                    r_ec <= w_second[X_W-1:0];
                  end else begin
                    r_sp <= w_first[Y_W-1:0];
                    r_ep <= w_second[Y_W-1:0];
                  end
                end
                r_state <= S_CMD;
              end
            endcase
          end
          S_RAMWR: begin
            if (!r_hi_pend) begin
              r_hi      <= w_byte;
              r_hi_pend <= 1'b1;
            end else begin
              r_hi_pend  <= 1'b0;
              r_px_valid <= 1'b1;
              r_px_x     <= r_x;
              r_px_y     <= r_y;
              r_px_color <= ILI9341_color_t'({r_hi, w_byte});
              // Raster advance inside the window; wrapping to the origin ends a frame.
              if (r_x < r_ec) begin
                r_x <= r_x + 1'b1;
              end else begin
                r_x <= r_sc;
                if (r_y < r_ep) begin
                  r_y <= r_y + 1'b1;
                end else begin
                  r_y          <= r_sp;
                  r_frame_done <= 1'b1;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign spi_miso   = 1'b0;
  assign cmd_valid  = r_cmd_valid;
  assign cmd        = r_cmd;
  assign px_valid   = r_px_valid;
  assign px_x       = r_px_x;
  assign px_y       = r_px_y;
  assign px_color   = r_px_color;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_ili9341_spi_responder.sv
// Self-checking bench for ili9341_spi_responder using a reduced 16x12 display
// so full-frame wrap is reachable in a short run.
module tb_ili9341_spi_responder;

  localparam int W  = 16;
  localparam int H  = 12;
  localparam int XW = $clog2(W) + 1;
  localparam int YW = $clog2(H) + 1;

  logic          clk = 1'b0;
  logic          rstb;
  logic          spi_csb;
  logic          spi_clk;
  logic          spi_mosi;
  logic          data_commandb;
  logic          spi_miso;
  logic          cmd_valid;
  logic [7:0]    cmd;
  logic          px_valid;
  logic [XW-1:0] px_x;
  logic [YW-1:0] px_y;
  logic [15:0]   px_color;
  logic          frame_done;

  always #5 clk = ~clk;

  ili9341_spi_responder #(.DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H)) dut (
    .clk           (clk),
    .rstb          (rstb),
    .spi_csb       (spi_csb),
    .spi_clk       (spi_clk),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso),
    .data_commandb (data_commandb),
    .cmd_valid     (cmd_valid),
    .cmd           (cmd),
    .px_valid      (px_valid),
    .px_x          (px_x),
    .px_y          (px_y),
    .px_color      (px_color),
    .frame_done    (frame_done)
  );

  typedef struct {int cyc; logic [7:0] c;} cmd_ev_t;
  typedef struct {int cyc; int x; int y; logic [15:0] c; bit fd;} px_ev_t;

  cmd_ev_t    cq[$];
  px_ev_t     pq[$];
  px_ev_t     obs[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         b0_cyc = 0;
  int         last_px_cyc = 0;
  bit         chk_en = 1'b0;
  logic [7:0] exp_cmd = 8'h00;

  // Reference model: byte-level view of the display, pixel position from a linear count.
  int         m_mode;  // 0 idle, 1 caset, 2 paset, 3 ramwr, 4 skip
  int         m_sc, m_ec, m_sp, m_ep, m_n, m_idx;
  int         m_par[4];
  bit         m_hi_pend;
  logic [7:0] m_hi;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_sc = 0; m_ec = W - 1; m_sp = 0; m_ep = H - 1;
    m_n = 0; m_idx = 0; m_hi_pend = 1'b0; m_hi = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit dc, input int ecyc);
    int s, e, lim, w, h, k;
    px_ev_t p;
    if (!dc) begin
      cq.push_back('{ecyc, b});
      m_hi_pend = 1'b0;
      m_idx = 0;
      case (b)
        8'h2A: m_mode = 1;
        8'h2B: m_mode = 2;
        8'h2C: begin m_mode = 3; m_n = 0; end
        8'h01: begin m_mode = 0; m_sc = 0; m_ec = W - 1; m_sp = 0; m_ep = H - 1; end
        default: m_mode = 4;
      endcase
    end else if (m_mode == 1 || m_mode == 2) begin
      m_par[m_idx] = int'(b);
      m_idx++;
      if (m_idx == 4) begin
        s = m_par[0] * 256 + m_par[1];
        e = m_par[2] * 256 + m_par[3];
        lim = (m_mode == 1) ? W - 1 : H - 1;
        if (s <= e && e <= lim) begin
          if (m_mode == 1) begin m_sc = s; m_ec = e; end
          else begin m_sp = s; m_ep = e; end
        end
        m_mode = 0;
      end
    end else if (m_mode == 3) begin
      if (!m_hi_pend) begin
        m_hi = b;
        m_hi_pend = 1'b1;
      end else begin
        w = m_ec - m_sc + 1;
        h = m_ep - m_sp + 1;
        k = m_n % (w * h);
        p.cyc = ecyc; p.x = m_sc + k % w; p.y = m_sp + k / w;
        p.c = {m_hi, b}; p.fd = (k == w * h - 1);
        pq.push_back(p);
        m_n++;
        m_hi_pend = 1'b0;
      end
    end
  endtask

  // Per-cycle comparison of every DUT output against the model's event queues.
  always @(negedge clk) begin
    bit ecv, epv, efd;
    px_ev_t o;
    if (chk_en) begin
      ecv = (cq.size() > 0) && (cq[0].cyc == cyc);
      epv = (pq.size() > 0) && (pq[0].cyc == cyc);
      efd = 1'b0;
      if (epv) efd = pq[0].fd;
      check("cmd_valid", 32'(cmd_valid), 32'(ecv));
      check("px_valid", 32'(px_valid), 32'(epv));
      check("frame_done", 32'(frame_done), 32'(efd));
      check("spi_miso", 32'(spi_miso), 32'd0);
      if (ecv) begin
        exp_cmd = cq[0].c;
        void'(cq.pop_front());
      end
      check("cmd", 32'(cmd), 32'(exp_cmd));
      if (epv) begin
        check("px_x", 32'(px_x), 32'(pq[0].x));
        check("px_y", 32'(px_y), 32'(pq[0].y));
        check("px_color", 32'(px_color), 32'(pq[0].c));
        void'(pq.pop_front());
      end
      while (cq.size() > 0 && cq[0].cyc < cyc) void'(cq.pop_front());
      while (pq.size() > 0 && pq[0].cyc < cyc) void'(pq.pop_front());
      if (px_valid) begin
        o.cyc = cyc; o.x = int'(px_x); o.y = int'(px_y); o.c = px_color; o.fd = frame_done;
        obs.push_back(o);
        last_px_cyc = cyc;
      end
    end
  end

  // One SPI bit: 2 clk low, 2 clk high (spi_clk = clk/4).
  task automatic spi_bit(input bit b, input bit dc, input bit is_b0);
    @(negedge clk); spi_mosi = b; data_commandb = dc; spi_clk = 1'b0;
    @(negedge clk);
    @(negedge clk); spi_clk = 1'b1;
    if (is_b0) b0_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit dc);
    for (int i = 7; i >= 0; i--) spi_bit(b[i], dc, i == 0);
    model_byte(b, dc, b0_cyc + 5);
  endtask

  task automatic csb_low();
    @(negedge clk); spi_csb = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic csb_high();
    @(negedge clk); spi_clk = 1'b0;
    repeat (2) @(negedge clk);
    spi_csb = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic drain();
    repeat (10) @(negedge clk);
  endtask

  task automatic send_pixel(input logic [15:0] c);
    send_byte(c[15:8], 1'b1);
    send_byte(c[7:0], 1'b1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ex[5], ey[5], efd[5];
    int nfd, fd_idx, r, n;
    logic [15:0] s, e;
    ex = '{10, 11, 10, 11, 10};
    ey = '{5, 5, 6, 6, 5};
    efd = '{0, 0, 0, 1, 0};

    rstb = 1'b0; spi_csb = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0; data_commandb = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_cmd", 32'(cmd), 32'h00);
    check("rst_px_valid", 32'(px_valid), 32'd0);
    check("rst_px_x", 32'(px_x), 32'd0);
    check("rst_px_y", 32'(px_y), 32'd0);
    check("rst_px_color", 32'(px_color), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_miso", 32'(spi_miso), 32'd0);
    rstb = 1'b1;
    chk_en = 1'b1;

    // First pixel after reset, with latency pin.
    csb_low();
    obs.delete();
    send_byte(8'h2C, 1'b0);
    send_pixel(16'hF800);
    drain();
    check("t1_count", 32'(obs.size()), 32'd1);
    check("t1_px_x", 32'(px_x), 32'd0);
    check("t1_px_y", 32'(px_y), 32'd0);
    check("t1_color", 32'(px_color), 32'hF800);
    check("t1_latency", 32'(last_px_cyc - (b0_cyc + 1)), 32'd4);
    check("t1_cmd", 32'(cmd), 32'h2C);

    // 2x2 window with wrap.
    obs.delete();
    send_byte(8'h2A, 1'b0); send_byte(8'h00, 1'b1); send_byte(8'h0A, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h0B, 1'b1);
    send_byte(8'h2B, 1'b0); send_byte(8'h00, 1'b1); send_byte(8'h05, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h06, 1'b1);
    send_byte(8'h2C, 1'b0);
    for (int i = 0; i < 5; i++) send_pixel(16'(16'h1000 + i));
    drain();
    check("t2_count", 32'(obs.size()), 32'd5);
    if (obs.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        check("t2_x", 32'(obs[i].x), 32'(ex[i]));
        check("t2_y", 32'(obs[i].y), 32'(ey[i]));
        check("t2_fd", 32'(obs[i].fd), 32'(efd[i]));
      end
    end

    // Rejected windows: SC>EC, then EC beyond the last column.
    obs.delete();
    send_byte(8'h2A, 1'b0); send_byte(8'h00, 1'b1); send_byte(8'h20, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1);
    send_byte(8'h2A, 1'b0); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'(W), 1'b1);
    send_byte(8'h2C, 1'b0);
    send_pixel(16'h07E0);
    drain();
    check("t3_count", 32'(obs.size()), 32'd1);
    check("t3_px_x", 32'(px_x), 32'd10);
    check("t3_px_y", 32'(px_y), 32'd5);

    // Command aborts a pending high byte.
    obs.delete();
    send_byte(8'h2C, 1'b0);
    send_byte(8'h12, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    drain();
    check("t4_no_px", 32'(obs.size()), 32'd0);
    check("t4_cmd", 32'(cmd), 32'h00);

    // Partial byte dropped by csb deassert; the RAMWR stream continues in the next frame.
    obs.delete();
    send_byte(8'h2C, 1'b0);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, 1'b1, 1'b0);
    csb_high();
    csb_low();
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    drain();
    check("t5_count", 32'(obs.size()), 32'd1);
    check("t5_color", 32'(px_color), 32'hABCD);
    check("t5_px_x", 32'(px_x), 32'd10);

    // Full default frame after SWRESET.
    obs.delete();
    send_byte(8'h01, 1'b0);
    send_byte(8'h2C, 1'b0);
    for (int i = 0; i < W * H + 1; i++) send_pixel(16'hFFFF);
    drain();
    nfd = 0; fd_idx = -1;
    foreach (obs[i]) if (obs[i].fd) begin nfd++; fd_idx = i; end
    check("t6_count", 32'(obs.size()), 32'(W * H + 1));
    check("t6_nfd", 32'(nfd), 32'd1);
    check("t6_fd_idx", 32'(fd_idx), 32'(W * H - 1));
    if (obs.size() == W * H + 1) begin
      check("t6_last_x", 32'(obs[W * H - 1].x), 32'(W - 1));
      check("t6_last_y", 32'(obs[W * H - 1].y), 32'(H - 1));
      check("t6_next_x", 32'(obs[W * H].x), 32'd0);
      check("t6_next_y", 32'(obs[W * H].y), 32'd0);
    end
    csb_high();

    // Randomized command/data mix.
    for (int op = 0; op < 30; op++) begin
      r = $urandom_range(0, 9);
      csb_low();
      case (r)
        0, 1, 2: begin
          s = 16'($urandom_range(0, W + 1));
          e = 16'($urandom_range(0, W + 1));
          if (r == 2) begin
            s = 16'($urandom_range(0, H + 1));
            e = 16'($urandom_range(0, H + 1));
          end
          if ($urandom_range(0, 7) == 0) e[8] = 1'b1;
          send_byte((r == 2) ? 8'h2B : 8'h2A, 1'b0);
          send_byte(s[15:8], 1'b1); send_byte(s[7:0], 1'b1);
          send_byte(e[15:8], 1'b1); send_byte(e[7:0], 1'b1);
        end
        3, 4, 5: begin
          send_byte(8'h2C, 1'b0);
          n = $urandom_range(1, 12);
          for (int j = 0; j < n; j++) begin
            send_pixel(16'($urandom));
            if ($urandom_range(0, 5) == 0) begin csb_high(); csb_low(); end
          end
          if ($urandom_range(0, 3) == 0) send_byte(8'($urandom), 1'b1);
        end
        6: repeat ($urandom_range(1, 3)) send_byte(8'($urandom), 1'b1);
        7: begin
          case ($urandom_range(0, 3))
            0: send_byte(8'h36, 1'b0);
            1: send_byte(8'h00, 1'b0);
            2: send_byte(8'h11, 1'b0);
            default: send_byte(8'h3A, 1'b0);
          endcase
          repeat ($urandom_range(0, 3)) send_byte(8'($urandom), 1'b1);
        end
        8: send_byte(8'h01, 1'b0);
        default: begin
          n = $urandom_range(1, 7);
          for (int j = 0; j < n; j++) spi_bit(1'($urandom), 1'b1, 1'b0);
          csb_high();
          csb_low();
          send_byte(8'($urandom), 1'b1);
        end
      endcase
      csb_high();
    end
    drain();

    // Asynchronous reset in the middle of a byte.
    csb_low();
    send_byte(8'h2A, 1'b0); send_byte(8'h00, 1'b1); send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h05, 1'b1);
    send_byte(8'h2B, 1'b0); send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h04, 1'b1);
    send_byte(8'h2C, 1'b0);
    send_pixel(16'hAA55);
    drain();
    check("t7_pre_x", 32'(px_x), 32'd3);
    check("t7_pre_y", 32'(px_y), 32'd2);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk_en = 1'b0;
    rstb = 1'b0;
    #1;
    check("arst_px_x", 32'(px_x), 32'd0);
    check("arst_px_y", 32'(px_y), 32'd0);
    check("arst_color", 32'(px_color), 32'd0);
    check("arst_cmd", 32'(cmd), 32'h00);
    check("arst_cmd_valid", 32'(cmd_valid), 32'd0);
    spi_clk = 1'b0;
    cq.delete(); pq.delete();
    model_reset();
    exp_cmd = 8'h00;
    @(negedge clk);
    rstb = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    obs.delete();
    send_byte(8'h2C, 1'b0);
    send_pixel(16'h1234);
    drain();
    check("t7_post_count", 32'(obs.size()), 32'd1);
    check("t7_post_x", 32'(px_x), 32'd0);
    check("t7_post_y", 32'(px_y), 32'd0);
    csb_high();
    drain();
    check("drain_cmd_q", 32'(cq.size()), 32'd0);
    check("drain_px_q", 32'(pq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
